// File: rtl/game_seq_ctrl.sv
// Round sequencer for the three-digit xAyB guessing game.
// It latches the secret answer and accepts guesses. Each guess is scored one
// digit pair per cycle, producing A (right digit, right place) and B (right
// digit, wrong place). It also counts attempts and decides win or loss.
// All outputs come straight from registers.
module game_seq_ctrl #(
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [3:0]  iNum1,
    input  logic [3:0]  iNum2,
    input  logic [3:0]  iNum3,
    input  logic        iNumRdy,
    input  logic        iRestart,
    output logic [2:0]  oState,
    output logic        oAnsLock,
    output logic [11:0] oAns,
    output logic [1:0]  oA,
    output logic [1:0]  oB,
    output logic [3:0]  oTries,
    output logic        oScoreVld,
    output logic        oErr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        SCORE = 3'd2,
        DONE  = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

    // An entry is legal only if it has three BCD digits that are pairwise distinct.
    function automatic logic entry_valid(input logic [11:0] e);
        return (e[11:8] <= 4'd9) && (e[7:4] <= 4'd9) && (e[3:0] <= 4'd9) &&
               (e[11:8] != e[7:4]) && (e[11:8] != e[3:0]) && (e[7:4] != e[3:0]);
    endfunction

    // Select a digit by position. Position 0 is the leftmost digit.
    function automatic logic [3:0] digit_at(input logic [11:0] v, input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = v[11:8];
            2'd1:    d = v[7:4];
            2'd2:    d = v[3:0];
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [11:0] ans_r, ans_nxt_s;
    logic [11:0] guess_r, guess_nxt_s;
    logic [1:0]  acc_a_r, acc_a_nxt_s, acc_a_upd_s;
    logic [1:0]  acc_b_r, acc_b_nxt_s, acc_b_upd_s;
    logic [1:0]  i_r, i_nxt_s;           // answer digit index
    logic [1:0]  j_r, j_nxt_s;           // guess digit index
    logic [1:0]  a_r, a_nxt_s;
    logic [1:0]  b_r, b_nxt_s;
    logic [3:0]  tries_r, tries_nxt_s;
    logic        vld_r, vld_nxt_s;
    logic        err_r, err_nxt_s;
    logic        lock_r, lock_nxt_s;
    logic [11:0] entry_s;
    logic        entry_ok_s;
    logic        pair_hit_s;

    assign entry_s    = {iNum1, iNum2, iNum3};
    assign entry_ok_s = entry_valid(entry_s);

    assign oState    = state_r;
    assign oAnsLock  = lock_r;
    assign oAns      = ans_r;
    assign oA        = a_r;
    assign oB        = b_r;
    assign oTries    = tries_r;
    assign oScoreVld = vld_r;
    assign oErr      = err_r;

    // Next-state logic: round sequencing, pair-by-pair scoring and result decision.
    always_comb begin
        state_nxt_s = state_r;
        ans_nxt_s   = ans_r;
        guess_nxt_s = guess_r;
        acc_a_nxt_s = acc_a_r;
        acc_b_nxt_s = acc_b_r;
        i_nxt_s     = i_r;
        j_nxt_s     = j_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        tries_nxt_s = tries_r;
        vld_nxt_s   = 1'b0;
        err_nxt_s   = 1'b0;
        acc_a_upd_s = acc_a_r;
        acc_b_upd_s = acc_b_r;

        // Score the current pair: guess[j] against ans[i].
        pair_hit_s = (digit_at(guess_r, j_r) == digit_at(ans_r, i_r));
        if (pair_hit_s && (i_r == j_r)) begin
            acc_a_upd_s = acc_a_r + 2'd1;
        end else if (pair_hit_s) begin
            acc_b_upd_s = acc_b_r + 2'd1;
        end else begin
            acc_a_upd_s = acc_a_r;
        end

        if (iRestart) begin
            state_nxt_s = IDLE;
            ans_nxt_s   = 12'd0;
            a_nxt_s     = 2'd0;
            b_nxt_s     = 2'd0;
            tries_nxt_s = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (iNumRdy && entry_ok_s) begin
                        ans_nxt_s   = entry_s;
                        tries_nxt_s = 4'd0;
                        a_nxt_s     = 2'd0;
                        b_nxt_s     = 2'd0;
                        state_nxt_s = PLAY;
                    end else if (iNumRdy) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                PLAY: begin
                    if (iNumRdy && entry_ok_s) begin
                        guess_nxt_s = entry_s;
                        acc_a_nxt_s = 2'd0;
                        acc_b_nxt_s = 2'd0;
                        i_nxt_s     = 2'd0;
                        j_nxt_s     = 2'd0;
                        state_nxt_s = SCORE;
                    end else if (iNumRdy) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = PLAY;
                    end
                end
                SCORE: begin
                    acc_a_nxt_s = acc_a_upd_s;
                    acc_b_nxt_s = acc_b_upd_s;
                    if ((i_r == 2'd2) && (j_r == 2'd2)) begin
                        // Last pair: publish the score so it is valid in DONE.
                        a_nxt_s     = acc_a_upd_s;
                        b_nxt_s     = acc_b_upd_s;
                        vld_nxt_s   = 1'b1;
                        state_nxt_s = DONE;
                        if (tries_r != MAX_T) begin
                            tries_nxt_s = tries_r + 4'd1;
                        end else begin
                            tries_nxt_s = tries_r;
                        end
                    end else if (j_r == 2'd2) begin
                        j_nxt_s = 2'd0;
                        i_nxt_s = i_r + 2'd1;
                    end else begin
                        j_nxt_s = j_r + 2'd1;
                    end
                end
                DONE: begin
                    if (a_r == 2'd3) begin
                        state_nxt_s = WIN;
                    end else if (tries_r == MAX_T) begin
                        state_nxt_s = LOSE;
                    end else begin
                        state_nxt_s = PLAY;
                    end
                end
                WIN:     state_nxt_s = WIN;
                LOSE:    state_nxt_s = LOSE;
                default: state_nxt_s = IDLE;
            endcase
        end

        lock_nxt_s = (state_nxt_s != IDLE);
    end

    // State and output registers, with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= IDLE;
            ans_r   <= 12'd0;
            guess_r <= 12'd0;
            acc_a_r <= 2'd0;
            acc_b_r <= 2'd0;
            i_r     <= 2'd0;
            j_r     <= 2'd0;
            a_r     <= 2'd0;
            b_r     <= 2'd0;
            tries_r <= 4'd0;
            vld_r   <= 1'b0;
            err_r   <= 1'b0;
            lock_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ans_r   <= ans_nxt_s;
            guess_r <= guess_nxt_s;
            acc_a_r <= acc_a_nxt_s;
            acc_b_r <= acc_b_nxt_s;
            i_r     <= i_nxt_s;
            j_r     <= j_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            tries_r <= tries_nxt_s;
            vld_r   <= vld_nxt_s;
            err_r   <= err_nxt_s;
            lock_r  <= lock_nxt_s;
        end
    end

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Self-checking bench for game_seq_ctrl. Expected values come from a
// digit-set scoring model and a simple round model kept in this file.
module tb_game_seq_ctrl;

    localparam int MAXT = 8;

    logic        CLK = 1'b0;
    logic        reset;
    logic [3:0]  iNum1, iNum2, iNum3;
    logic        iNumRdy, iRestart;
    logic [2:0]  oState;
    logic        oAnsLock;
    logic [11:0] oAns;
    logic [1:0]  oA, oB;
    logic [3:0]  oTries;
    logic        oScoreVld, oErr;

    int checks = 0;
    int errors = 0;

    game_seq_ctrl #(.MAX_TRIES(MAXT)) dut (
        .CLK(CLK), .reset(reset),
        .iNum1(iNum1), .iNum2(iNum2), .iNum3(iNum3),
        .iNumRdy(iNumRdy), .iRestart(iRestart),
        .oState(oState), .oAnsLock(oAnsLock), .oAns(oAns),
        .oA(oA), .oB(oB), .oTries(oTries),
        .oScoreVld(oScoreVld), .oErr(oErr)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    function automatic logic [3:0] dig(input logic [11:0] v, input int p);
        logic [11:0] t;
        t = v >> (4 * (2 - p));
        return t[3:0];
    endfunction

    function automatic bit ref_valid(input logic [11:0] v);
        bit ok = 1'b1;
        for (int p = 0; p < 3; p++) if (dig(v, p) > 4'd9) ok = 1'b0;
        for (int p = 0; p < 3; p++)
            for (int q = p + 1; q < 3; q++)
                if (dig(v, p) == dig(v, q)) ok = 1'b0;
        return ok;
    endfunction

    // A = positions that agree; B = shared digits minus A.
    function automatic logic [3:0] ref_score(input logic [11:0] ans, input logic [11:0] g);
        int a = 0;
        int common = 0;
        bit in_ans;
        for (int p = 0; p < 3; p++) if (dig(ans, p) == dig(g, p)) a++;
        for (int q = 0; q < 3; q++) begin
            in_ans = 1'b0;
            for (int p = 0; p < 3; p++) if (dig(ans, p) == dig(g, q)) in_ans = 1'b1;
            if (in_ans) common++;
        end
        return {2'(a), 2'(common - a)};
    endfunction

    function automatic logic [11:0] rand_valid();
        logic [11:0] v;
        do begin
            v = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
        end while (!ref_valid(v));
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic enter(input logic [11:0] v);
        iNum1 = v[11:8]; iNum2 = v[7:4]; iNum3 = v[3:0];
        iNumRdy = 1'b1;
        tick();
        iNumRdy = 1'b0;
    endtask

    task automatic restart();
        iRestart = 1'b1;
        tick();
        iRestart = 1'b0;
    endtask

    // Bounded wait for the score pulse; n is the number of ticks taken.
    task automatic wait_vld(output int n);
        n = 0;
        while (oScoreVld !== 1'b1 && n < 15) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; iRestart = 1'b0; iNumRdy = 1'b0;
        iNum1 = 4'd0; iNum2 = 4'd0; iNum3 = 4'd0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({oState, oAnsLock, oAns, oA, oB, oTries, oScoreVld, oErr} !== 26'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0",
                     {oState, oAnsLock, oAns, oA, oB, oTries, oScoreVld, oErr});
        end
        tick();
        checks++;
        if (oState !== 3'd0) begin
            errors++; $display("FAIL reset_idle_hold: got %0d expected 0", oState);
        end
    endtask

    task automatic test_exact();
        int n;
        enter(12'h123);
        checks++;
        if ({oState, oAnsLock, oAns} !== {3'd1, 1'b1, 12'h123}) begin
            errors++; $display("FAIL exact_answer_latch: got %h expected %h",
                               {oState, oAnsLock, oAns}, {3'd1, 1'b1, 12'h123});
        end
        enter(12'h123);
        checks++;
        if (oState !== 3'd2) begin
            errors++; $display("FAIL exact_score_state: got %0d expected 2", oState);
        end
        wait_vld(n);
        checks++;
        if (n !== 9) begin
            errors++; $display("FAIL exact_latency: got %0d expected 9 ticks after cycle 1", n);
        end
        checks++;
        if ({oA, oB, oTries, oState} !== {2'd3, 2'd0, 4'd1, 3'd3}) begin
            errors++; $display("FAIL exact_score: got %h expected %h",
                               {oA, oB, oTries, oState}, {2'd3, 2'd0, 4'd1, 3'd3});
        end
        tick();
        checks++;
        if ({oState, oScoreVld} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL exact_win: got %h expected %h", {oState, oScoreVld}, {3'd4, 1'b0});
        end
        enter(12'h456);
        checks++;
        if ({oState, oErr, oA, oTries} !== {3'd4, 1'b0, 2'd3, 4'd1}) begin
            errors++; $display("FAIL win_hold: got %h expected %h",
                               {oState, oErr, oA, oTries}, {3'd4, 1'b0, 2'd3, 4'd1});
        end
    endtask

    task automatic test_mixed();
        int n;
        restart();
        checks++;
        if ({oState, oAnsLock, oAns, oA, oB, oTries} !== 24'd0) begin
            errors++; $display("FAIL mixed_restart_clear: got %h expected 0",
                               {oState, oAnsLock, oAns, oA, oB, oTries});
        end
        enter(12'h123);
        enter(12'h324);
        wait_vld(n);
        checks++;
        if ({oA, oB, oTries} !== {2'd1, 2'd1, 4'd1} || n !== 9) begin
            errors++; $display("FAIL mixed_score: got %h (n=%0d) expected %h (n=9)",
                               {oA, oB, oTries}, n, {2'd1, 2'd1, 4'd1});
        end
        tick();
        checks++;
        if (oState !== 3'd1) begin
            errors++; $display("FAIL mixed_back_to_play: got %0d expected 1", oState);
        end
    endtask

    task automatic test_invalid();
        logic [11:0] bad [2];
        bad[0] = 12'h115;
        bad[1] = 12'h1A3;
        restart();
        for (int t = 0; t < 2; t++) begin
            enter(bad[t]);
            checks++;
            if ({oErr, oState, oAns, oAnsLock} !== {1'b1, 3'd0, 12'h000, 1'b0}) begin
                errors++; $display("FAIL invalid_entry_%0d: got %h expected %h", t,
                                   {oErr, oState, oAns, oAnsLock}, {1'b1, 3'd0, 12'h000, 1'b0});
            end
            tick();
            checks++;
            if (oErr !== 1'b0) begin
                errors++; $display("FAIL invalid_err_pulse_%0d: got %b expected 0", t, oErr);
            end
        end
    endtask

    task automatic test_loss();
        int n;
        restart();
        enter(12'h123);
        for (int g = 1; g <= MAXT; g++) begin
            enter(12'h456);
            wait_vld(n);
            checks++;
            if ({oA, oB, oTries} !== {2'd0, 2'd0, 4'(g)}) begin
                errors++; $display("FAIL loss_guess_%0d: got %h expected %h", g,
                                   {oA, oB, oTries}, {2'd0, 2'd0, 4'(g)});
            end
            tick();
            checks++;
            if (oState !== ((g == MAXT) ? 3'd5 : 3'd1)) begin
                errors++; $display("FAIL loss_state_%0d: got %0d expected %0d", g, oState,
                                   (g == MAXT) ? 5 : 1);
            end
        end
        enter(12'h456);
        checks++;
        if ({oState, oErr, oTries, oScoreVld} !== {3'd5, 1'b0, 4'd8, 1'b0}) begin
            errors++; $display("FAIL loss_hold: got %h expected %h",
                               {oState, oErr, oTries, oScoreVld}, {3'd5, 1'b0, 4'd8, 1'b0});
        end
    endtask

    task automatic test_restart_mid();
        bit saw = 1'b0;
        restart();
        enter(12'h123);
        enter(12'h789);
        for (int c = 0; c < 4; c++) tick();
        iRestart = 1'b1;
        tick();
        iRestart = 1'b0;
        checks++;
        if ({oState, oTries, oAns, oAnsLock} !== {3'd0, 4'd0, 12'h000, 1'b0}) begin
            errors++; $display("FAIL restart_mid: got %h expected 0",
                               {oState, oTries, oAns, oAnsLock});
        end
        for (int c = 0; c < 12; c++) begin
            if (oScoreVld === 1'b1) saw = 1'b1;
            tick();
        end
        checks++;
        if (saw !== 1'b0 || oState !== 3'd0) begin
            errors++; $display("FAIL restart_no_score: got vld_seen=%b state=%0d expected 0/0", saw, oState);
        end
    endtask

    task automatic test_simul();
        int n;
        enter(12'h123);
        iRestart = 1'b1;
        iNum1 = 4'd4; iNum2 = 4'd5; iNum3 = 4'd6; iNumRdy = 1'b1;
        tick();
        iRestart = 1'b0; iNumRdy = 1'b0;
        tick();
        checks++;
        if ({oState, oAns, oErr, oTries} !== 20'd0) begin
            errors++; $display("FAIL simul_restart_wins: got %h expected 0", {oState, oAns, oErr, oTries});
        end
        enter(12'h135);
        enter(12'h153);
        tick(); tick();
        enter(12'h135);
        checks++;
        if ({oState, oErr} !== {3'd2, 1'b0}) begin
            errors++; $display("FAIL score_ignore_strobe: got %h expected %h", {oState, oErr}, {3'd2, 1'b0});
        end
        wait_vld(n);
        checks++;
        if ({oA, oB, oTries} !== {2'd1, 2'd2, 4'd1} || n !== 6) begin
            errors++; $display("FAIL score_unaffected: got %h (n=%0d) expected %h (n=6)",
                               {oA, oB, oTries}, n, {2'd1, 2'd2, 4'd1});
        end
    endtask

    task automatic test_random();
        logic [11:0] ans, g;
        logic [3:0]  exp_ab;
        int          tries, n, guard, kind;
        bit          over;
        logic [2:0]  exp_st;
        for (int r = 0; r < 6; r++) begin
            restart();
            ans = rand_valid();
            enter(ans);
            checks++;
            if ({oState, oAns} !== {3'd1, ans}) begin
                errors++; $display("FAIL rand_answer_%0d: got %h expected %h", r, {oState, oAns}, {3'd1, ans});
            end
            tries = 0; over = 1'b0; guard = 0;
            while (!over && guard < 30) begin
                guard++;
                kind = $urandom_range(7, 0);
                g = rand_valid();
                if (kind == 0) begin
                    g[7:4] = g[11:8];
                end else if (kind == 1) begin
                    g[3:0] = 4'($urandom_range(15, 10));
                end else if (kind == 2) begin
                    g = ans;
                end
                enter(g);
                if (!ref_valid(g)) begin
                    checks++;
                    if ({oErr, oState, oTries} !== {1'b1, 3'd1, 4'(tries)}) begin
                        errors++; $display("FAIL rand_invalid_%h: got %h expected %h", g,
                                           {oErr, oState, oTries}, {1'b1, 3'd1, 4'(tries)});
                    end
                    tick();
                end else begin
                    exp_ab = ref_score(ans, g);
                    tries++;
                    wait_vld(n);
                    checks++;
                    if ({oA, oB, oTries} !== {exp_ab, 4'(tries)} || n !== 9) begin
                        errors++; $display("FAIL rand_score ans=%h g=%h: got %h (n=%0d) expected %h (n=9)",
                                           ans, g, {oA, oB, oTries}, n, {exp_ab, 4'(tries)});
                    end
                    tick();
                    if (exp_ab[3:2] == 2'd3) begin
                        exp_st = 3'd4; over = 1'b1;
                    end else if (tries == MAXT) begin
                        exp_st = 3'd5; over = 1'b1;
                    end else begin
                        exp_st = 3'd1;
                    end
                    checks++;
                    if (oState !== exp_st) begin
                        errors++; $display("FAIL rand_next_state: got %0d expected %0d", oState, exp_st);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_mixed();
        test_invalid();
        test_loss();
        test_restart_mid();
        test_simul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_seq_ctrl.md
# game_seq_ctrl

Round sequencer for the three-digit "xAyB" guessing game. It latches the secret answer from the keypad entry path and accepts guesses. Each guess is scored against the answer by a sequential 9-pair digit comparison, producing A (right digit, right place) and B (right digit, wrong place) counts. The block counts attempts and decides win or loss. Its state, score and answer outputs drive the VGA text overlay (start banner, xAyB hint line, result).

## Interface
- MAX_TRIES, 8, guesses allowed per round; legal range 1..15
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high; clock CLK
- iNum1, iNum2, iNum3  in  4 each  BCD digits from the keypad path; iNum1 is the leftmost digit
- iNumRdy  in  1  one-cycle strobe; the digits are valid in the same cycle
- iRestart  in  1  level or pulse; abandons the round and returns to IDLE
- oState  out  3  IDLE=0, PLAY=1, SCORE=2, DONE=3, WIN=4, LOSE=5
- oAnsLock  out  1  high in every state except IDLE
- oAns  out  12  latched answer {d1,d2,d3}
- oA, oB  out  2 each  score of the last completed guess
- oTries  out  4  completed guesses this round
- oScoreVld  out  1  one-cycle pulse when oA, oB and oTries are updated
- oErr  out  1  one-cycle pulse when an entry is rejected

## Operation
- Reset values: oState=IDLE, oAnsLock=0, oAns=0, oA=0, oB=0, oTries=0, oScoreVld=0, oErr=0.
- Entry validity:
  - An entry is invalid if any digit is greater than 9, or if any two of the three digits are equal.
  - An invalid iNumRdy in IDLE or PLAY pulses oErr. The state and all registers are unchanged.
- IDLE:
  - A valid iNumRdy latches the digits into oAns.
  - oTries, oA and oB clear to 0. Next state is PLAY.
- PLAY:
  - A valid iNumRdy latches the digits into an internal guess register.
  - The A and B accumulators and the pair counter k clear to 0. Next state is SCORE.
- SCORE:
  - One pair per cycle, k = 0..8, with i = k/3 and j = k%3.
  - If guess[j] == ans[i]: when i == j, increment the A accumulator; otherwise increment the B accumulator.
  - After k = 8 is processed, the next state is DONE.
  - With distinct digits, A+B ≤ 3, so 2-bit accumulators never overflow.
- DONE (exactly one cycle):
  - oA and oB take the accumulator values.
  - oTries increments by 1.
  - oScoreVld = 1.
- Next state after DONE:
  - WIN if A == 3.
  - Otherwise LOSE if the new oTries == MAX_TRIES.
  - Otherwise PLAY.
  - WIN takes precedence when the final try is correct.
- WIN and LOSE hold all outputs until iRestart.
- iNumRdy is ignored (no oErr) in SCORE, DONE, WIN and LOSE.
- iRestart:
  - In any state, the next state is IDLE, and oAns, oA, oB and oTries clear to 0.
  - It takes priority over iNumRdy in the same cycle.
  - reset takes priority over iRestart.
- oTries never exceeds MAX_TRIES and never wraps.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- iNumRdy is sampled at the rising edge ending cycle 0.
  - Cycle 1: the state is PLAY (answer entry) or SCORE (guess entry). For an invalid entry, oErr = 1 in cycle 1 only.
  - Cycles 1..9: SCORE, pairs k = 0..8.
  - Cycle 10: DONE, with oScoreVld = 1 and oA, oB, oTries already holding the new values.
  - Cycle 11: PLAY, WIN or LOSE.
- Guess-to-score latency is 10 cycles. The minimum spacing between accepted guesses is 11 cycles; strobes arriving earlier are dropped.
- oA, oB and oTries change only at the edge into DONE, or on reset or iRestart. They are stable for the display at all other times.
- Reset or iRestart during SCORE aborts the round. Nothing is scored, and oScoreVld does not pulse.

## Test plan
- Answer entry and exact guess:
  - Stimulus: reset, then iNumRdy with 1,2,3, then iNumRdy with 1,2,3.
  - Response: oAns=0x123; oScoreVld pulses 10 cycles after the guess strobe; oA=3, oB=0, oTries=1; oState=WIN next cycle.
- Mixed score:
  - Stimulus: answer 1,2,3, then guess 3,2,4.
  - Response: oA=1, oB=1, oTries=1; oState returns to PLAY.
- Invalid entries:
  - Stimulus: in IDLE, enter 1,1,5; then enter 1,A,3.
  - Response: each produces a single oErr pulse; oState stays IDLE; oAns stays 0.
- Loss path (MAX_TRIES=8):
  - Stimulus: answer 1,2,3, then eight guesses of 4,5,6.
  - Response: each guess gives oA=0, oB=0; after the eighth, oTries=8 and oState=LOSE; a further iNumRdy produces no oErr and no change.
- Restart mid-score:
  - Stimulus: assert iRestart in cycle 5 after a guess strobe.
  - Response: oState=IDLE on the next cycle; oScoreVld never pulses; oTries=0, oAns=0, oAnsLock=0.
- Simultaneous and ignored events:
  - Stimulus: iRestart and iNumRdy in the same cycle in PLAY.
  - Response: IDLE is entered and the guess is discarded.
  - Stimulus: iNumRdy strobed during SCORE.
  - Response: the strobe is ignored and the scoring in progress is unaffected.
